// File: rtl/mio_bus_pkg.sv
// mio_bus_pkg: address map, widths, select bundle and FSM state type for the MIO bus bridge.
package mio_bus_pkg;
  localparam int DW = 32;
  localparam int RAM_AW = 10;
  localparam logic [DW-1:0] RAM_BASE = 32'h0000_0000;
  localparam logic [DW-1:0] RAM_MASK = 32'hFFFF_F000;
  localparam logic [DW-1:0] GPIO_BASE = 32'hE000_0000;
  localparam logic [DW-1:0] SW_BASE = 32'hF000_0000;
  localparam logic [DW-1:0] IO_MASK = 32'hFFFF_FFFC;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;
  typedef struct packed {
    logic ram;
    logic gpio;
    logic sw;
    logic unmapped;
  } sel_t;
endpackage

// File: rtl/mio_addr_decode.sv
// mio_addr_decode: maps a byte address onto the RAM, GPIO and SW/DISP regions.
module mio_addr_decode import mio_bus_pkg::*; (
  input  logic [DW-1:0] addr_bus,
  output logic          sel_ram,
  output logic          sel_gpio,
  output logic          sel_sw,
  output logic          sel_unmapped
);
  assign sel_ram = (addr_bus & RAM_MASK) == RAM_BASE;
  assign sel_gpio = (addr_bus & IO_MASK) == GPIO_BASE;
  assign sel_sw = (addr_bus & IO_MASK) == SW_BASE;
  assign sel_unmapped = !(sel_ram || sel_gpio || sel_sw);
endmodule

// File: rtl/mio_bus_bridge.sv
// mio_bus_bridge: CPU MIO request to RAM/GPIO/SW-DISP bridge with a 4-state FSM.
// Define MIO_BUS_ERR_EN to enable the sticky bus_err flag; otherwise bus_err is tied low.
module mio_bus_bridge import mio_bus_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mio,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [DW-1:0]     addr_bus,
  input  logic [DW-1:0]     cpu_data_out,
  output logic [DW-1:0]     cpu_data_in,
  output logic              mio_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_din,
  output logic              ram_we,
  input  logic [DW-1:0]     ram_dout,
  output logic [DW-1:0]     gpio_out,
  output logic [DW-1:0]     disp_out,
  input  logic [15:0]       sw_in,
  output logic              bus_err
);
  logic sel_ram, sel_gpio, sel_sw, sel_unmapped, accept;
  state_e state_q, state_d;
  sel_t sel_q, sel_d;
  logic wr_q, wr_d, mio_ready_q, mio_ready_d, ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d, cpu_data_in_q, cpu_data_in_d;
  logic [DW-1:0] gpio_q, gpio_d, disp_q, disp_d;

  mio_addr_decode u_dec (
    .addr_bus     (addr_bus),
    .sel_ram      (sel_ram),
    .sel_gpio     (sel_gpio),
    .sel_sw       (sel_sw),
    .sel_unmapped (sel_unmapped)
  );

  assign accept = state_q == IDLE && cpu_mio && (mem_r || mem_w);

  // ram_din_q doubles as the latched write data for IO writes too
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    wr_d = wr_q;
    mio_ready_d = 1'b0;
    ram_we_d = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d = ram_din_q;
    cpu_data_in_d = cpu_data_in_q;
    gpio_d = gpio_q;
    disp_d = disp_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ACCESS;
        sel_d = '{ram: sel_ram, gpio: sel_gpio, sw: sel_sw, unmapped: sel_unmapped};
        wr_d = mem_w;
        ram_addr_d = addr_bus[RAM_AW+1:2];
        ram_din_d = cpu_data_out;
        ram_we_d = mem_w && sel_ram;
      end
      ACCESS: begin
        state_d = (sel_q.ram && !wr_q) ? WAIT : RESP;
        mio_ready_d = !(sel_q.ram && !wr_q);
        gpio_d = (wr_q && sel_q.gpio) ? ram_din_q : gpio_q;
        disp_d = (wr_q && sel_q.sw) ? ram_din_q : disp_q;
        if (!wr_q && !sel_q.ram)
          cpu_data_in_d = sel_q.unmapped ? '0 : sel_q.gpio ? gpio_q : {16'b0, sw_in};
      end
      WAIT: begin
        state_d = RESP;
        mio_ready_d = 1'b1;
        cpu_data_in_d = ram_dout;
      end
      RESP: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q <= '0;
      wr_q <= 1'b0;
      mio_ready_q <= 1'b0;
      ram_we_q <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q <= '0;
      cpu_data_in_q <= '0;
      gpio_q <= '0;
      disp_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      wr_q <= wr_d;
      mio_ready_q <= mio_ready_d;
      ram_we_q <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q <= ram_din_d;
      cpu_data_in_q <= cpu_data_in_d;
      gpio_q <= gpio_d;
      disp_q <= disp_d;
    end
  end

`ifdef MIO_BUS_ERR_EN
  logic bus_err_q, bus_err_d;
  assign bus_err_d = bus_err_q || (accept && ((mem_r && mem_w) || sel_unmapped));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus_err_q <= 1'b0;
    else bus_err_q <= bus_err_d;
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign cpu_data_in = cpu_data_in_q;
  assign mio_ready = mio_ready_q;
  assign ram_addr = ram_addr_q;
  assign ram_din = ram_din_q;
  assign ram_we = ram_we_q;
  assign gpio_out = gpio_q;
  assign disp_out = disp_q;
endmodule

// File: tb/tb_mio_bus_bridge.sv
// tb_mio_bus_bridge: directed and random transactions against a transaction-level model of the bridge.
module tb_mio_bus_bridge;
  logic clk = 1'b0;
  logic reset, cpu_mio = 0, mem_r = 0, mem_w = 0;
  logic [31:0] addr_bus = 0, cpu_data_out = 0, cpu_data_in, ram_din, ram_dout, gpio_out, disp_out;
  logic mio_ready, ram_we, bus_err;
  logic [9:0] ram_addr;
  logic [15:0] sw_in = 0;
  int checks = 0, errors = 0;
  logic [31:0] mem [1024];
  logic [31:0] ref_ram [1024];
  logic [31:0] ref_gpio = 0, ref_disp = 0, ref_rdata = 0;
  logic ref_err = 0;
  int we_cnt = 0;
  logic [9:0] we_addr;
  logic [31:0] we_din;

  always #5 clk = ~clk;

  mio_bus_bridge dut (
    .clk(clk), .reset(reset), .cpu_mio(cpu_mio), .mem_r(mem_r), .mem_w(mem_w),
    .addr_bus(addr_bus), .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
    .mio_ready(mio_ready), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .gpio_out(gpio_out), .disp_out(disp_out), .sw_in(sw_in),
    .bus_err(bus_err)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) if (ram_we) begin
    we_cnt++;
    we_addr = ram_addr;
    we_din = ram_din;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    if (a < 32'h1000) return 0;
    if (a >= 32'hE000_0000 && a <= 32'hE000_0003) return 1;
    if (a >= 32'hF000_0000 && a <= 32'hF000_0003) return 2;
    return 3;
  endfunction

  task automatic check_outputs_zero();
    check("rst_ready", mio_ready, 0);
    check("rst_rdata", cpu_data_in, 0);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_din", ram_din, 0);
    check("rst_gpio", gpio_out, 0);
    check("rst_disp", disp_out, 0);
    check("rst_err", bus_err, 0);
  endtask

  task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int c, rg;
    rg = region(a);
    @(negedge clk);
    cpu_mio = 1; mem_r = r; mem_w = w; addr_bus = a; cpu_data_out = d; we_cnt = 0;
    @(posedge clk); #1;
    cpu_mio = 0; mem_r = 1'($urandom); mem_w = 1'($urandom);
    addr_bus = $urandom; cpu_data_out = $urandom;
    if (w) begin
      if (rg == 0) ref_ram[a[11:2]] = d;
      else if (rg == 1) ref_gpio = d;
      else if (rg == 2) ref_disp = d;
    end else
      ref_rdata = rg == 0 ? ref_ram[a[11:2]] : rg == 1 ? ref_gpio : rg == 2 ? {16'h0, sw_in} : 32'h0;
`ifdef MIO_BUS_ERR_EN
    if ((r && w) || rg == 3) ref_err = 1;
`endif
    c = 1;
    while (!mio_ready && c < 8) begin
      @(posedge clk); #1;
      c++;
    end
    check("latency", c, (!w && rg == 0) ? 3 : 2);
    check("rdata", cpu_data_in, ref_rdata);
    check("gpio", gpio_out, ref_gpio);
    check("disp", disp_out, ref_disp);
    check("bus_err", bus_err, ref_err);
    check("we_cnt", we_cnt, (w && rg == 0) ? 1 : 0);
    if (w && rg == 0) begin
      check("we_addr", we_addr, a[11:2]);
      check("we_din", we_din, d);
    end
    @(posedge clk); #1;
    check("ready_pulse", mio_ready, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = i * 32'h0101_0101 + 32'h1357;
      ref_ram[i] = i * 32'h0101_0101 + 32'h1357;
    end
    reset = 1;
    #3 reset = 0;
    #5 check_outputs_zero();
    @(negedge clk) reset = 1;

    txn(0, 1, 32'h10, 32'hDEADBEEF);
    txn(1, 0, 32'h10, 0);
    check("ram_rd_beef", cpu_data_in, 32'hDEADBEEF);
    sw_in = 16'hA5A5;
    txn(1, 0, 32'hF000_0000, 0);
    check("sw_rd", cpu_data_in, 32'h0000_A5A5);
    txn(0, 1, 32'hF000_0000, 32'h1234);
    check("disp_wr", disp_out, 32'h1234);
    txn(0, 1, 32'hE000_0000, 32'h55);
    txn(1, 0, 32'hE000_0000, 0);
    check("gpio_rd", cpu_data_in, 32'h55);
    txn(1, 0, 32'h8000_0000, 0);
    check("unmapped_rd", cpu_data_in, 0);
    txn(1, 0, 32'h0000_0FFF, 0);
    txn(0, 1, 32'h0000_1000, 32'h1111_2222);
    txn(1, 0, 32'hE000_0004, 0);
    txn(1, 1, 32'h0000_0014, 32'hA0B0_C0D0);
    txn(1, 0, 32'h0000_0014, 0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int k;
      sw_in = 16'($urandom);
      case ($urandom_range(0, 3))
        0: a = {20'h0, 12'($urandom)};
        1: a = 32'hE000_0000 | $urandom_range(0, 3);
        2: a = 32'hF000_0000 | $urandom_range(0, 3);
        default: a = $urandom;
      endcase
      k = $urandom_range(0, 4);
      txn(k < 2 || k == 4, k >= 2, a, $urandom);
    end

    @(negedge clk);
    cpu_mio = 1; mem_r = 0; mem_w = 1; addr_bus = 32'h20; cpu_data_out = 32'hCAFE_F00D;
    @(posedge clk); #1;
    cpu_mio = 0;
    check("abort_we", ram_we, 1);
    reset = 0;
    #1 check_outputs_zero();
    ref_gpio = 0; ref_disp = 0; ref_rdata = 0; ref_err = 0;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_noready", mio_ready, 0);
    end
    @(negedge clk) reset = 1;
    txn(1, 0, 32'h20, 0);
    check("abort_old", cpu_data_in, 32'd8 * 32'h0101_0101 + 32'h1357);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
